// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding, phase lengths and transaction shadow type for the I2C sequencer
package i2c_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MRST = 3'd1;
   localparam logic [2:0] ST_HDR  = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_STOP = 3'd4;
   localparam logic [2:0] ST_RESP = 3'd5;
   localparam logic [3:0] HDR_CYCLES  = 4'd10;
   localparam logic [3:0] BYTE_CYCLES = 4'd9;
   localparam logic [3:0] STOP_CYCLES = 4'd2;
   // master state numbering, for observers of the master itself
   localparam logic [3:0] M_IDLE        = 4'd0;
   localparam logic [3:0] M_START       = 4'd1;
   localparam logic [3:0] M_ADDRESS     = 4'd2;
   localparam logic [3:0] M_MODE        = 4'd3;
   localparam logic [3:0] M_ADDRESS_ACK = 4'd4;
   localparam logic [3:0] M_DATA        = 4'd5;
   localparam logic [3:0] M_DATA_ACK    = 4'd6;
   localparam logic [3:0] M_STOP        = 4'd7;
   localparam logic [3:0] M_DONE        = 4'd8;
   typedef struct packed {
      logic        rw;
      logic [6:0]  addr;
      logic [1:0]  nb;
      logic [31:0] wd;
   } txn_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; on a tie the requester not granted last wins
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic last;
   always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) last <= 1'b1;
      else if (en && |req) last <= gnt[1];
endmodule

// File: rtl/i2c_sequencer.sv
// i2c_sequencer: arbitrates two transaction requesters and drives the I2C master with cycle-exact timing
module i2c_sequencer
   import i2c_pkg::*;
#(
   parameter int NBYTES_MAX = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [1:0]              req,
   input  logic [1:0]              rw,
   input  logic [6:0]              addr0,
   input  logic [6:0]              addr1,
   input  logic [1:0]              nbytes0,
   input  logic [1:0]              nbytes1,
   input  logic [8*NBYTES_MAX-1:0] wdata0,
   input  logic [8*NBYTES_MAX-1:0] wdata1,
   output logic [1:0]              ack,
   output logic [8*NBYTES_MAX-1:0] rdata,
   output logic                    nack_err,
   output logic                    m_reset_n,
   output logic                    m_en,
   output logic                    m_start,
   output logic                    m_stop,
   output logic                    m_mode,
   output logic [6:0]              m_address,
   output logic [7:0]              m_registor,
   input  logic [7:0]              m_data_out,
   input  logic                    sda_in
);
   logic [2:0] state;
   logic [3:0] cnt;
   logic [1:0] bytecnt;
   logic [1:0] gnt;
   logic       win;
   logic       act;
   txn_t       sh;
   rr_arb2 u_arb (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (state == ST_IDLE),
      .req    (req),
      .gnt    (gnt)
   );
   always_comb act = (state == ST_HDR) || (state == ST_DATA) || (state == ST_STOP);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bytecnt  <= '0;
         sh       <= '0;
         win      <= 1'b0;
         rdata    <= '0;
         nack_err <= 1'b0;
      end else
         case (state)
            ST_IDLE: if (|req) begin
               state    <= ST_MRST;
               win      <= gnt[1];
               sh       <= gnt[1] ? {rw[1], addr1, nbytes1, wdata1} : {rw[0], addr0, nbytes0, wdata0};
               bytecnt  <= '0;
               rdata    <= '0;
               nack_err <= 1'b0;
            end
            ST_MRST: begin
               state <= ST_HDR;
               cnt   <= '0;
            end
            // last header cycle is the address ACK slot
            ST_HDR: if (cnt == HDR_CYCLES - 4'd1) begin
               cnt      <= '0;
               nack_err <= sda_in;
               state    <= sda_in ? ST_STOP : ST_DATA;
            end else cnt <= cnt + 4'd1;
            ST_DATA: if (cnt == BYTE_CYCLES - 4'd1) begin
               cnt <= '0;
               if (sh.rw) rdata[{bytecnt, 3'b000} +: 8] <= m_data_out;
               if (!sh.rw && sda_in) begin
                  nack_err <= 1'b1;
                  state    <= ST_STOP;
               end else if (bytecnt == sh.nb) state <= ST_STOP;
               else bytecnt <= bytecnt + 2'd1;
            end else cnt <= cnt + 4'd1;
            ST_STOP: if (cnt == STOP_CYCLES - 4'd1) state <= ST_RESP;
                     else cnt <= cnt + 4'd1;
            default: state <= ST_IDLE;
         endcase
   // master controls are registered copies of the current phase
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ack        <= '0;
         m_reset_n  <= 1'b0;
         m_en       <= 1'b0;
         m_start    <= 1'b0;
         m_stop     <= 1'b0;
         m_mode     <= 1'b0;
         m_address  <= '0;
         m_registor <= '0;
      end else begin
         ack        <= (state == ST_RESP) ? (win ? 2'b10 : 2'b01) : 2'b00;
         m_reset_n  <= state != ST_MRST;
         m_en       <= act;
         m_start    <= (state == ST_HDR) || (state == ST_DATA);
         m_stop     <= (state == ST_STOP) || ((state == ST_DATA) && (bytecnt == sh.nb));
         m_mode     <= act && sh.rw;
         m_address  <= act ? sh.addr : 7'd0;
         m_registor <= ((state == ST_HDR) || (state == ST_DATA)) ? sh.wd[{bytecnt, 3'b000} +: 8] : 8'd0;
      end
endmodule

// File: tb/tb_i2c_sequencer.sv
// tb_i2c_sequencer: directed self-checking bench with a cycle-counting slave model
module tb_i2c_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req = '0;
   logic [1:0]  rw = '0;
   logic [6:0]  addr0 = '0, addr1 = '0;
   logic [1:0]  nbytes0 = '0, nbytes1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic [7:0]  m_data_out = '0;
   logic        sda_in = 1'b0;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic        nack_err, m_reset_n, m_en, m_start, m_stop, m_mode;
   logic [6:0]  m_address;
   logic [7:0]  m_registor;
   int          checks = 0;
   int          failures = 0;
   int          mcnt = 0;
   logic [7:0]  rbytes [4];
   logic [7:0]  reg_seen [4];
   logic        stop_seen [4];
   logic [6:0]  addr_seen;
   logic        mode_seen;

   always #5 clk = ~clk;

   i2c_sequencer dut (
      .clk(clk), .reset_n(reset_n), .req(req), .rw(rw),
      .addr0(addr0), .addr1(addr1), .nbytes0(nbytes0), .nbytes1(nbytes1),
      .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata), .nack_err(nack_err),
      .m_reset_n(m_reset_n), .m_en(m_en), .m_start(m_start), .m_stop(m_stop), .m_mode(m_mode),
      .m_address(m_address), .m_registor(m_registor), .m_data_out(m_data_out), .sda_in(sda_in)
   );

   // mcnt counts enabled cycles: 1..10 header, then 9 per byte, mid-byte k at 15+9k
   always @(negedge clk) begin
      mcnt = m_en ? mcnt + 1 : 0;
      m_data_out = (mcnt < 10) ? 8'h00 : rbytes[(mcnt > 45) ? 3 : (mcnt - 10) / 9];
      if (mcnt == 5) begin
         addr_seen = m_address;
         mode_seen = m_mode;
      end
      for (int k = 0; k < 4; k++)
         if (mcnt == 15 + 9 * k) begin
            reg_seen[k]  = m_registor;
            stop_seen[k] = m_stop;
         end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctl"}, {25'd0, ack, nack_err, m_reset_n, m_en, m_start, m_stop, m_mode}, 32'd0);
      check({tag, "_addr_reg"}, {17'd0, m_address, m_registor}, 32'd0);
      check({tag, "_rdata"}, rdata, 32'd0);
   endtask

   task automatic do_txn(input int who, input int exp_lat, input logic [31:0] exp_rdata,
                         input logic exp_nack, input string tag);
      int lat;
      @(negedge clk);
      req[who] = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (ack == 2'b00 && lat < 200);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_ack"}, {30'd0, ack}, (who == 1) ? 32'd2 : 32'd1);
      check({tag, "_rdata"}, rdata, exp_rdata);
      check({tag, "_nack"}, {31'd0, nack_err}, {31'd0, exp_nack});
      req[who] = 1'b0;
   endtask

   initial begin
      rbytes = '{8'h0F, 8'h00, 8'h00, 8'h00};
      repeat (3) @(posedge clk);
      #1 check_reset("rst");
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1 check("idle_m_reset_n", {31'd0, m_reset_n}, 32'd1);

      rw[0] = 1'b1; addr0 = 7'h70; nbytes0 = 2'd0;
      do_txn(0, 23, 32'h0000000F, 1'b0, "rd1");
      check("rd1_addr", {25'd0, addr_seen}, 32'h70);
      check("rd1_mode", {31'd0, mode_seen}, 32'd1);

      rw[0] = 1'b0; addr0 = 7'h11; nbytes0 = 2'd1; wdata0 = 32'h00001234; sda_in = 1'b1;
      do_txn(0, 14, 32'h0, 1'b1, "nack");
      sda_in = 1'b0;

      rw[1] = 1'b0; addr1 = 7'h70; nbytes1 = 2'd1; wdata1 = 32'h0000A5F0;
      do_txn(1, 32, 32'h0, 1'b0, "wr2");
      check("wr2_byte0", {24'd0, reg_seen[0]}, 32'hF0);
      check("wr2_byte1", {24'd0, reg_seen[1]}, 32'hA5);
      check("wr2_stop0", {31'd0, stop_seen[0]}, 32'd0);
      check("wr2_stop1", {31'd0, stop_seen[1]}, 32'd1);
      check("wr2_mode", {31'd0, mode_seen}, 32'd0);

      rw = 2'b11; addr0 = 7'h70; addr1 = 7'h70; nbytes0 = 2'd0; nbytes1 = 2'd0;
      @(negedge clk) req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         int lat;
         lat = 0;
         do begin
            @(posedge clk);
            #1;
            lat++;
         end while (ack == 2'b00 && lat < 100);
         check($sformatf("rr_grant%0d", i), {30'd0, ack}, (i % 2 == 1) ? 32'd2 : 32'd1);
      end
      req = 2'b00;

      rbytes = '{8'h12, 8'h34, 8'h56, 8'h78};
      nbytes1 = 2'd3;
      do_txn(1, 50, 32'h78563412, 1'b0, "rd4");
      check("rd4_stop0", {31'd0, stop_seen[0]}, 32'd0);
      check("rd4_stop1", {31'd0, stop_seen[1]}, 32'd0);
      check("rd4_stop2", {31'd0, stop_seen[2]}, 32'd0);
      check("rd4_stop3", {31'd0, stop_seen[3]}, 32'd1);

      rw[0] = 1'b1; nbytes0 = 2'd3;
      @(negedge clk) req[0] = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk) reset_n = 1'b0;
      #1 check_reset("rst_mid");
      req[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      rbytes[0] = 8'h5A; nbytes0 = 2'd0;
      do_txn(0, 23, 32'h0000005A, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end
endmodule
